// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and the status flag layout shared by the ALU files
package alu_pkg;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic op_err;
    } flags_t;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: logical and arithmetic right shifts by the full unsigned amount
module alu_shifter #(
    parameter int N_BITS = 8
) (
    input  logic [N_BITS-1:0] d,
    input  logic [N_BITS-1:0] sh,
    output logic [N_BITS-1:0] srl,
    output logic [N_BITS-1:0] sra
);
    localparam logic [N_BITS-1:0] lim = N_BITS'(N_BITS);
    logic big;
    always_comb begin
        big = sh >= lim;
        srl = big ? '0 : d >> sh;
        sra = big ? {N_BITS{d[N_BITS-1]}} : N_BITS'($signed(d) >>> sh);
    end
endmodule

// File: rtl/alu.sv
// alu: combinational N_BITS-wide ALU with a registered condition-flag status register
module alu
    import alu_pkg::*;
#(
    parameter int N_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] d0,
    input  logic [N_BITS-1:0] d1,
    input  logic [5:0]        opcode,
    output logic [N_BITS-1:0] out,
    output logic              zero,
    output logic              negative,
    output logic              carry,
    output logic              overflow,
    output logic              op_err
);
    localparam int M = N_BITS - 1;
    logic [N_BITS:0]   sum, diff;
    logic [N_BITS-1:0] srl, sra;
    flags_t            nxt, flg;

    alu_shifter #(.N_BITS(N_BITS)) u_shifter (
        .d   (d0),
        .sh  (d1),
        .srl (srl),
        .sra (sra)
    );

    // the extra top bit of diff is the unsigned borrow
    assign sum  = {1'b0, d0} + {1'b0, d1};
    assign diff = {1'b0, d0} - {1'b0, d1};

    always_comb begin
        out          = '0;
        nxt.carry    = 1'b0;
        nxt.overflow = 1'b0;
        nxt.op_err   = 1'b0;
        case (opcode)
            OP_ADD: begin
                out          = sum[M:0];
                nxt.carry    = sum[N_BITS];
                nxt.overflow = (d0[M] == d1[M]) && (sum[M] != d0[M]);
            end
            OP_SUB: begin
                out          = diff[M:0];
                nxt.carry    = diff[N_BITS];
                nxt.overflow = (d0[M] != d1[M]) && (diff[M] != d0[M]);
            end
            OP_AND:  out = d0 & d1;
            OP_OR:   out = d0 | d1;
            OP_XOR:  out = d0 ^ d1;
            OP_NOR:  out = ~(d0 | d1);
            OP_SRA:  out = sra;
            OP_SRL:  out = srl;
            default: nxt.op_err = 1'b1;
        endcase
        nxt.zero     = out == '0;
        nxt.negative = out[M];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flg <= '0;
        else     flg <= nxt;
    end

    assign zero     = flg.zero;
    assign negative = flg.negative;
    assign carry    = flg.carry;
    assign overflow = flg.overflow;
    assign op_err   = flg.op_err;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors with hand-computed results and flags for the 8-bit ALU
module tb_alu;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d0 = '0, d1 = '0, out;
    logic [5:0] opcode = '0;
    logic       zero, negative, carry, overflow, op_err;
    int         n = 0, errs = 0;

    alu #(.N_BITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .d0       (d0),
        .d1       (d1),
        .opcode   (opcode),
        .out      (out),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .overflow (overflow),
        .op_err   (op_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                         input string tag, input logic [7:0] exp);
        @(negedge clk);
        opcode = op;
        d0     = a;
        d1     = b;
        #1 check(tag, {24'd0, out}, {24'd0, exp});
    endtask

    // flags packed as {zero, negative, carry, overflow, op_err}
    task automatic edge_flags(input string tag, input logic [4:0] exp);
        @(posedge clk);
        #1 check(tag, {27'd0, zero, negative, carry, overflow, op_err}, {27'd0, exp});
    endtask

    initial begin
        #2 check("reset_flags", {27'd0, zero, negative, carry, overflow, op_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(6'b100000, 8'd1,   8'd1,   "add_1_1",  8'd2);
        apply(6'b100010, 8'd4,   8'd1,   "sub_4_1",  8'd3);
        apply(6'b100100, 8'd3,   8'd2,   "and_3_2",  8'd2);
        apply(6'b100101, 8'd4,   8'd3,   "or_4_3",   8'd7);
        apply(6'b100110, 8'd3,   8'd1,   "xor_3_1",  8'd2);
        apply(6'b100111, 8'hFE,  8'hFE,  "nor_fe",   8'd1);
        apply(6'b000011, 8'd12,  8'd1,   "sra_12_1", 8'd6);
        apply(6'b000010, 8'd12,  8'd1,   "srl_12_1", 8'd6);
        apply(6'b000011, 8'h80,  8'd1,   "sra_80_1", 8'hC0);
        apply(6'b000010, 8'h80,  8'd1,   "srl_80_1", 8'h40);
        apply(6'b000011, 8'h80,  8'd9,   "sra_80_9", 8'hFF);
        apply(6'b000010, 8'h80,  8'd9,   "srl_80_9", 8'h00);
        apply(6'b000011, 8'h80,  8'd8,   "sra_80_8", 8'hFF);
        apply(6'b000010, 8'hC3,  8'd0,   "srl_by_0", 8'hC3);
        apply(6'b000011, 8'h40,  8'd200, "sra_pos_big", 8'h00);
        apply(6'b100000, 8'hFF,  8'h01,  "add_ff_1", 8'h00);
        edge_flags("flags_add_ff_1", 5'b10100);
        apply(6'b100000, 8'h7F,  8'h01,  "add_7f_1", 8'h80);
        edge_flags("flags_add_7f_1", 5'b01010);
        apply(6'b100010, 8'd1,   8'd2,   "sub_1_2",  8'hFF);
        edge_flags("flags_sub_1_2", 5'b01100);
        apply(6'b100010, 8'h80,  8'h01,  "sub_80_1", 8'h7F);
        edge_flags("flags_sub_80_1", 5'b00010);
        apply(6'b111111, 8'h5A,  8'hA5,  "bad_op",   8'h00);
        edge_flags("flags_bad_op", 5'b10001);
        apply(6'b100100, 8'd3,   8'd2,   "and_after_bad", 8'd2);
        edge_flags("flags_after_bad", 5'b00000);
        apply(6'b100000, 8'h7F,  8'h01,  "add_pre_rst", 8'h80);
        edge_flags("flags_pre_rst", 5'b01010);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_flags_async", {27'd0, zero, negative, carry, overflow, op_err}, 32'd0);
        check("rst_out_live", {24'd0, out}, 32'h80);
        opcode = 6'b100010;
        d0     = 8'd4;
        d1     = 8'd1;
        #1 check("rst_out_tracks", {24'd0, out}, 32'd3);
        edge_flags("rst_held_edge", 5'b00000);
        @(negedge clk);
        opcode = 6'b100000;
        d0     = 8'hFF;
        d1     = 8'h01;
        rst    = 1'b0;
        #1 check("rst_released_pre_edge", {27'd0, zero, negative, carry, overflow, op_err}, 32'd0);
        edge_flags("rst_reload", 5'b10100);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- Parameterised N_BITS-wide integer ALU for the datapath; executes one of eight MIPS-funct-style operations on two operands selected by a 6-bit opcode.
- Result path is purely combinational: out settles within the same delta/time step as the inputs.
- A clocked status register captures condition flags of the current result on every rising clock edge. It is cleared by an asynchronous, active-high reset.

Parameters:
- N_BITS, 8, operand and result width in bits; legal values are 2 or more.

Ports:
- clk, input, 1, system clock; flags sample on the rising edge.
- rst, input, 1, asynchronous active-high reset; clears the flag registers.
- d0, input, N_BITS, operand A; the shifted value for shift operations.
- d1, input, N_BITS, operand B; the shift amount for shift operations.
- opcode, input, 6, operation select.
- out, output, N_BITS, combinational result.
- zero, output, 1, registered: the previous-cycle result was all zeros.
- negative, output, 1, registered: the MSB of the previous-cycle result.
- carry, output, 1, registered: ADD carry-out, or SUB borrow; 0 for all other operations.
- overflow, output, 1, registered: two's-complement overflow of ADD/SUB; 0 for all other operations.
- op_err, output, 1, registered: the previous-cycle opcode was not in the supported set.

Behaviour:
- Opcode encodings and results, all truncated to N_BITS:
  - 100000 ADD: d0 + d1
  - 100010 SUB: d0 - d1
  - 100100 AND: d0 & d1
  - 100101 OR: d0 | d1
  - 100110 XOR: d0 ^ d1
  - 100111 NOR: ~(d0 | d1)
  - 000011 SRA: d0 shifted right arithmetically (sign-filled) by unsigned d1
  - 000010 SRL: d0 shifted right logically (zero-filled) by unsigned d1
- Any other opcode: out = 0.
- out is fully combinational. There is no latency and no dependency on clk or rst; out stays valid even while rst is asserted.
- Shift boundaries: d1 = 0 passes d0 through unchanged. If d1 >= N_BITS, SRL gives all zeros and SRA gives all copies of d0[N_BITS-1]. Only the unsigned value of d1 is used, with no masking to log2 bits.
- carry:
  - ADD: bit N_BITS of the (N_BITS+1)-bit sum.
  - SUB: 1 when d0 < d1 as unsigned (borrow).
- overflow: computed as signed.
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from d0.
- Flag register:
  - rst = 1: zero, negative, carry, overflow and op_err all go to 0 immediately, independent of clk.
  - Otherwise, each rising clk edge loads all five flags from the current combinational values. There is no enable; flags are updated every cycle.
  - If rst is released coincident with a clock edge, the flags stay 0 for that edge and load on the next edge.
- No handshake and no internal state beyond the five flag flops.

Decomposition:
- Package alu_pkg holds:
  - localparams for the eight opcodes, e.g. OP_ADD = 6'b100000.
  - a packed flags struct {zero, negative, carry, overflow, op_err}.
- Sub-module alu_shifter (parameter N_BITS) implements SRA/SRL, including the out-of-range shift handling.
- The top level holds the opcode case, the adder/subtractor with carry/overflow, and the async-reset flag register.

Test Plan (N_BITS = 8):
- Logic and arithmetic, each checked 1 time unit after applying the inputs:
  - ADD 1+1 -> out = 2
  - SUB 4-1 -> out = 3
  - AND 3&2 -> out = 2
  - OR 4|3 -> out = 7
  - XOR 3^1 -> out = 2
  - NOR 0xFE,0xFE -> out = 1
- Shifts:
  - SRA 12>>>1 -> out = 6
  - SRL 12>>1 -> out = 6
  - SRA 0x80 by 1 -> out = 0xC0
  - SRL 0x80 by 1 -> out = 0x40
  - SRA 0x80 by 9 -> out = 0xFF
  - SRL 0x80 by 9 -> out = 0x00
- Flags after one clk edge:
  - ADD 0xFF+0x01 -> out = 0, zero = 1, carry = 1, overflow = 0
  - ADD 0x7F+0x01 -> out = 0x80, overflow = 1, negative = 1
  - SUB 1-2 -> out = 0xFF, carry (borrow) = 1, negative = 1
- Invalid opcode 6'b111111 with any operands -> out = 0; op_err = 1 after the clk edge; op_err returns to 0 after a valid opcode and the next edge.
- Reset:
  - Assert rst between clock edges with flags set -> all flags read 0 immediately, and out still tracks the inputs.
  - Deassert rst -> the flags reload on the following rising edge.
